// File: rtl/sync_pkg.sv
// Shared constants and helpers for the sync_stream task-argument path.
// Pure declarations; no logic, no latency, no flow control.
package sync_pkg;

  localparam int TASK_W_DEF  = 128;
  localparam int ARG_W_DEF   = 64;
  localparam int ARG_LSB_DEF = 64;

  // Width needed to hold 0..depth inclusive, so a full FIFO is representable.
  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: data written at edge t is at popData from cycle t+1.
// Backpressure: push ignored when full, pop ignored when empty; popData reads 0 when empty.
module sync_fifo
  import sync_pkg::*;
#(
  parameter int WIDTH = ARG_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic [WIDTH-1:0]             popData,
  output logic                         full,
  output logic                         empty,
  output logic [cntWidth(DEPTH)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cntWidth(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;
  assign popData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge ap_clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      if (doPush && !doPop) begin
        count <= count + CNT_W'(1);
      end else if (doPop && !doPush) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sync_stream.sv
// Round-robin merge of N_CH task streams into one argument stream; 1-cycle accept-to-output latency.
// Backpressure: one granted channel sees TREADY when the FIFO is not full; output obeys VALID/READY.
module sync_stream
  import sync_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int TASK_W  = TASK_W_DEF,
  parameter int ARG_W   = ARG_W_DEF,
  parameter int ARG_LSB = ARG_LSB_DEF,
  parameter int DEPTH   = 4
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [N_CH*TASK_W-1:0]      taskIn_TDATA,
  input  logic [N_CH-1:0]             taskIn_TVALID,
  output logic [N_CH-1:0]             taskIn_TREADY,
  output logic [ARG_W-1:0]            argOut_TDATA,
  output logic                        argOut_TVALID,
  input  logic                        argOut_TREADY,
  output logic [cntWidth(DEPTH)-1:0]  occupancy,
  output logic                        dropped_none
);

  localparam int LG_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [LG_W-1:0]  lastGrant;
  logic [LG_W-1:0]  grantIdx;
  logic [LG_W-1:0]  probe;
  logic [N_CH-1:0]  grant;
  logic             found;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             push;
  logic [ARG_W-1:0] selArg;
  logic             unusedTaskBits;

  // Search starts one past the last winner, so a busy channel cannot starve its neighbours.
  always_comb begin
    grant    = '0;
    grantIdx = lastGrant;
    found    = 1'b0;
    probe    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      probe = LG_W'((int'(lastGrant) + k) % N_CH);
      if (!found && taskIn_TVALID[probe]) begin
        found          = 1'b1;
        grant[probe]   = 1'b1;
        grantIdx       = probe;
      end
    end
  end

  always_comb begin
    selArg = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        selArg = taskIn_TDATA[i*TASK_W + ARG_LSB +: ARG_W];
      end
    end
  end

  // A full FIFO refuses input even when draining this cycle: no pass-through path.
  assign taskIn_TREADY = grant & {N_CH{ap_rst_n & ~fifoFull}};
  assign push          = |(taskIn_TVALID & taskIn_TREADY);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      lastGrant <= LG_W'(N_CH - 1);
    end else if (push) begin
      lastGrant <= grantIdx;
    end
  end

  sync_fifo #(
    .WIDTH (ARG_W),
    .DEPTH (DEPTH)
  ) uFifo (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .push     (push),
    .pushData (selArg),
    .pop      (argOut_TREADY),
    .popData  (argOut_TDATA),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (occupancy)
  );

  assign argOut_TVALID  = ~fifoEmpty;
  assign dropped_none   = 1'b1;
  assign unusedTaskBits = ^taskIn_TDATA;

endmodule
